mdu_sequencer: RTL
==================

# mdu_sequencer

Multi-cycle multiply/divide sequencer for the EX stage. It accepts one MDU operation at a time and runs division as a 32-step restoring iteration on internal registers. Multiplication goes to the external multiplier: operands are held stable for `MUL_LAT` cycles, then the product is captured. The result is held until the pipeline accepts it. The EX stage uses `busy` and `req_ready` to stall, and `flush` to cancel an in-flight operation.

## Interface
Parameters:
- `DATA_WIDTH`, 32: operand/result width; only 32 is supported.
- `MUL_LAT`, 2: cycles `mul_x/mul_y/mul_signed` are held before `mul_res` is sampled; legal range 1..8.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: an operation is offered.
- `req_ready` out 1: the sequencer can accept; equals `state==IDLE && !flush`.
- `req_op` in 3: operation code.
  - 000 MUL, 001 MULH, 010 MULHU.
  - 100 DIV, 101 MOD, 110 DIVU, 111 MODU.
  - 011 is illegal and returns 0 after 1 cycle.
- `req_src1` in 32: dividend / multiplicand.
- `req_src2` in 32: divisor / multiplier.
- `flush` in 1: cancel the current operation and discard its result.
- `resp_valid` out 1: `resp_data` is valid.
- `resp_ready` in 1: the consumer takes the result.
- `resp_data` out 32: the result.
- `busy` out 1: `state != IDLE`.
- `mul_signed` out 1: signed-multiply select to the external multiplier.
- `mul_x`, `mul_y` out 32: registered multiplier operands.
- `mul_res` in 64: external multiplier product.

## Operation
State machine states: IDLE, MUL, DIV, DONE.

- **IDLE**
  - On `req_valid && req_ready`, latch `req_op`, `req_src1` and `req_src2`.
  - `req_op[2]==0` → MUL:
    - drive `mul_x=src1`, `mul_y=src2`;
    - `mul_signed = (op != MULHU)`;
    - load the counter with `MUL_LAT-1`.
  - `req_op[2]==1` with divisor==0 → DONE: quotient = 32'hFFFFFFFF, remainder = src1 unmodified, no sign fix.
  - `req_op[2]==1` with divisor!=0 → DIV:
    - signed (`op[1]==0`): take the magnitudes `|src1|` and `|src2|`, record `qneg = s1^s2` and `rneg = s1`;
    - unsigned: use the operands directly, with `qneg = rneg = 0`;
    - load the counter with 31 and clear the 33-bit partial remainder.
  - Op 011 → DONE with result 0.
- **MUL**
  - The counter decrements each cycle; `mul_x/mul_y/mul_signed` are held constant.
  - At counter==0: capture `mul_res[31:0]` (MUL) or `mul_res[63:32]` (MULH/MULHU) into the result register, then → DONE.
- **DIV**, one iteration per cycle:
  - `rem = {rem[31:0], dvd[31]}`; shift the dividend left.
  - If `rem >= {1'b0,dvs}`: `rem -= dvs` and quotient bit = 1; otherwise the quotient bit = 0.
  - After the iteration with counter==0, apply signs:
    - quotient negated if `qneg`;
    - remainder negated if `rneg`.
  - Select the quotient (DIV/DIVU) or the remainder (MOD/MODU), then → DONE.
- **DONE**
  - `resp_valid=1` and `resp_data` = the result register, held stable while `resp_ready==0`.
  - On `resp_ready` → IDLE. No new request is accepted in that same cycle.
- **Signed overflow**: `0x80000000 / 0xFFFFFFFF` gives quotient 0x80000000 and remainder 0 by natural wrap; no special case.
- **Flush**
  - In any state, `flush` forces IDLE on the next edge and drops `resp_valid`; the result is lost.
  - `flush` together with `req_valid` in IDLE: the request is not accepted.
  - `flush` in DONE together with `resp_ready`: the flush wins, and the consumer must treat the result as discarded.
- **Reset** (asynchronous, any time, including mid-division):
  - state IDLE, counter 0;
  - `resp_valid`, `resp_data`, `mul_x`, `mul_y` and `mul_signed` all 0;
  - `busy=0`, `req_ready=1`.

## Timing
- Accept edge = T0.
- **MUL latency**:
  - `resp_valid` rises at T0+`MUL_LAT`+1;
  - `mul_res` is sampled at the edge ending the last MUL cycle, i.e. `MUL_LAT` cycles after the operands became valid.
- **DIV latency**: 32 iteration cycles + 1, so `resp_valid` rises at T0+33.
- **Divide-by-zero and illegal op**: `resp_valid` at T0+1.
- **Throughput**: at most one operation per latency+1 cycles. The earliest next accept is the cycle after DONE is consumed.
- `busy` rises the cycle after accept and falls the cycle after the response handshake or flush.
- `resp_data` and `resp_valid` come straight from registers, with no combinational path from any input.
- `req_ready` is combinational from `state` and `flush`.

## Test plan
- **DIV signed**: src1=0xFFFFFFF9 (−7), src2=2, op DIV. Expect `resp_valid` at T0+33 with `resp_data`=0xFFFFFFFD (−3). Repeat with op MOD: expect 0xFFFFFFFF (−1).
- **DIVU / MODU**:
  - 100/7 gives 14 and 2.
  - 0x80000000 / 0xFFFFFFFF with op DIV gives 0x80000000; with op MOD gives 0.
- **Divide by zero**: src1=0x1234, src2=0.
  - DIVU: 0xFFFFFFFF at T0+1.
  - MODU: 0x1234 at T0+1.
- **MUL path with `MUL_LAT`=2 and a model multiplier**:
  - MULH 0xFFFFFFFF×2 → 0xFFFFFFFF;
  - MULHU of the same operands → 0x00000001;
  - MUL → 0xFFFFFFFE;
  - each at T0+3, with `mul_x/mul_y` constant through the MUL state.
- **Backpressure**: hold `resp_ready=0` for 5 cycles in DONE. `resp_data` stays stable, `req_ready=0` even with `req_valid` high, and no second accept occurs.
- **Flush and reset**:
  - Flush at iteration 10 of a DIV: IDLE next cycle, no `resp_valid`, and a following DIVU 9/3 returns 3 at its own T0+33.
  - Assert `rst` mid-MUL: all outputs are 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mdu_sequencer.sv
// ---------------------------------------------------------------------------
// mdu_sequencer
//
// Multi-cycle multiply/divide sequencer for the EX stage. One operation is in
// flight at a time. Division runs as a restoring shift/subtract loop, one
// quotient bit per cycle. Multiplication is delegated to an external
// multiplier: operands are registered, held for MUL_LAT cycles, then the
// product half of interest is captured. The result is held in DONE until the
// consumer takes it.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   req_valid/req_ready   request handshake (req_ready = IDLE && !flush)
//   req_op                000 MUL, 001 MULH, 010 MULHU, 011 illegal,
//                         100 DIV, 101 MOD, 110 DIVU, 111 MODU
//   req_src1/req_src2     dividend/multiplicand, divisor/multiplier
//   flush                 cancel the current operation, drop its result
//   resp_valid/ready/data response handshake and registered result
//   busy                  state != IDLE
//   mul_signed/x/y        registered operands to the external multiplier
//   mul_res               external multiplier product
//
// State | Meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a request
// MUL   | operands held on mul_x/mul_y, counting down the multiplier latency
// DIV   | one restoring-division iteration per cycle
// DONE  | resp_valid high, result held until resp_ready
// ---------------------------------------------------------------------------
module mdu_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int MUL_LAT    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [2:0]              req_op,
    input  logic [DATA_WIDTH-1:0]   req_src1,
    input  logic [DATA_WIDTH-1:0]   req_src2,
    input  logic                    flush,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [DATA_WIDTH-1:0]   resp_data,
    output logic                    busy,
    output logic                    mul_signed,
    output logic [DATA_WIDTH-1:0]   mul_x,
    output logic [DATA_WIDTH-1:0]   mul_y,
    input  logic [2*DATA_WIDTH-1:0] mul_res
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DATA_WIDTH - 1);

    localparam logic [2:0] OP_MUL     = 3'b000;
    localparam logic [2:0] OP_MULHU   = 3'b010;
    localparam logic [2:0] OP_ILLEGAL = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [2:0]              op_q;
    logic [DATA_WIDTH-1:0]   dvd_q;      // dividend shifting out, quotient shifting in
    logic [DATA_WIDTH-1:0]   dvs_q;
    logic [DATA_WIDTH-1:0]   rem_q;      // partial remainder is always < divisor
    logic                    qneg_q;
    logic                    rneg_q;

    // ------------------------------------------------------------------
    // Request-side decode
    // ------------------------------------------------------------------
    logic                  accept;
    logic                  src1_neg;
    logic                  src2_neg;
    logic [DATA_WIDTH-1:0] src1_mag;
    logic [DATA_WIDTH-1:0] src2_mag;

    assign req_ready = (state == ST_IDLE) && !flush;
    assign busy      = (state != ST_IDLE);
    assign accept    = req_valid && req_ready;

    // Only signed ops (op[1]==0) treat the top bit as a sign
    assign src1_neg = req_src1[DATA_WIDTH-1] & ~req_op[1];
    assign src2_neg = req_src2[DATA_WIDTH-1] & ~req_op[1];
    assign src1_mag = src1_neg ? -req_src1 : req_src1;
    assign src2_mag = src2_neg ? -req_src2 : req_src2;

    // ------------------------------------------------------------------
    // One restoring-division iteration. The borrow bit of the 33-bit
    // difference doubles as the "remainder < divisor" compare.
    // ------------------------------------------------------------------
    logic [DATA_WIDTH:0]   rem_sh;
    logic [DATA_WIDTH:0]   rem_diff;
    logic                  q_bit;
    logic [DATA_WIDTH-1:0] rem_nxt;
    logic [DATA_WIDTH-1:0] quo_nxt;
    logic [DATA_WIDTH-1:0] quo_fix;
    logic [DATA_WIDTH-1:0] rem_fix;

    always_comb begin
        rem_sh   = {rem_q, dvd_q[DATA_WIDTH-1]};
        rem_diff = rem_sh - {1'b0, dvs_q};
        q_bit    = ~rem_diff[DATA_WIDTH];
        rem_nxt  = q_bit ? rem_diff[DATA_WIDTH-1:0] : rem_sh[DATA_WIDTH-1:0];
        quo_nxt  = {dvd_q[DATA_WIDTH-2:0], q_bit};
        quo_fix  = qneg_q ? -quo_nxt : quo_nxt;
        rem_fix  = rneg_q ? -rem_nxt : rem_nxt;
    end

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            op_q       <= '0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            rem_q      <= '0;
            qneg_q     <= 1'b0;
            rneg_q     <= 1'b0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            mul_x      <= '0;
            mul_y      <= '0;
            mul_signed <= 1'b0;
        end else if (flush) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            resp_valid <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_q <= req_op;
                        if (req_op == OP_ILLEGAL) begin
                            resp_data  <= '0;
                            resp_valid <= 1'b1;
                            state      <= ST_DONE;
                        end else if (!req_op[2]) begin
                            mul_x      <= req_src1;
                            mul_y      <= req_src2;
                            mul_signed <= (req_op != OP_MULHU);
                            cnt        <= MUL_LOAD;
                            state      <= ST_MUL;
                        end else if (req_src2 == '0) begin
                            // Divide by zero: all-ones quotient, raw dividend as remainder
                            resp_data  <= req_op[0] ? req_src1 : '1;
                            resp_valid <= 1'b1;
                            state      <= ST_DONE;
                        end else begin
                            dvd_q  <= src1_mag;
                            dvs_q  <= src2_mag;
                            qneg_q <= src1_neg ^ src2_neg;
                            rneg_q <= src1_neg;
                            rem_q  <= '0;
                            cnt    <= DIV_LOAD;
                            state  <= ST_DIV;
                        end
                    end
                end

                ST_MUL: begin
                    if (cnt == '0) begin
                        resp_data  <= (op_q == OP_MUL) ? mul_res[DATA_WIDTH-1:0]
                                                       : mul_res[2*DATA_WIDTH-1:DATA_WIDTH];
                        resp_valid <= 1'b1;
                        state      <= ST_DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                ST_DIV: begin
                    rem_q <= rem_nxt;
                    dvd_q <= quo_nxt;
                    if (cnt == '0) begin
                        resp_data  <= op_q[0] ? rem_fix : quo_fix;
                        resp_valid <= 1'b1;
                        state      <= ST_DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                ST_DONE: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
